// File: rtl/analog_io_sampler.sv
// Pad input sampler for one analog project: resynchronise, debounce and queue pad changes.
// Optional ANALOG_SAMPLER_TIMESTAMP_EN adds a 16-bit timestamp (evt_time) to every queued event.
module analog_io_sampler #(
    parameter int PADS       = 38,
    parameter int DEBOUNCE_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  active,
    input  logic [PADS-1:0]       io_in,
    input  logic [PADS-1:0]       io_mask,
    input  logic [DEBOUNCE_W-1:0] debounce_cycles,
    output logic [PADS-1:0]       in_stable,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [PADS-1:0]       evt_data,
    output logic                  evt_overflow,
    input  logic                  clear_overflow
`ifdef ANALOG_SAMPLER_TIMESTAMP_EN
    ,
    output logic [15:0]           evt_time
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PADS-1:0]       sync1_q, sync2_q;
    logic [PADS-1:0]       cand_q, cand_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic [PADS-1:0]       stable_q, stable_d;
    logic                  push_q, push_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [PADS-1:0]       mem_q [FIFO_DEPTH];

    logic [PADS-1:0] masked;
    logic            fifo_empty, fifo_full, pop, push_ok, drop;

    assign masked     = sync2_q & io_mask;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && evt_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok    = push_q && (!fifo_full || pop);
    assign drop       = push_q && fifo_full && !pop;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        push_d   = 1'b0;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (!active) begin
            cand_d   = '0;
            cnt_d    = '0;
            stable_d = '0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (masked != cand_q) begin
                cand_d = masked;
                cnt_d  = '0;
            end else if (cand_q != stable_q) begin
                // Live compare: lowering the threshold below cnt stalls until cand changes.
                if (cnt_q == debounce_cycles) begin
                    stable_d = cand_q;
                    push_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            ovf_d = (ovf_q && !clear_overflow) || drop;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            push_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q  <= io_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            push_q   <= push_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (active && push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= stable_q;
        end
    end

    assign in_stable    = stable_q;
    assign evt_valid    = !fifo_empty;
    assign evt_data     = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign evt_overflow = ovf_q;

`ifdef ANALOG_SAMPLER_TIMESTAMP_EN
    logic [15:0] timer_q, timer_d;
    logic [15:0] ptime_q, ptime_d;
    logic [15:0] tmem_q [FIFO_DEPTH];

    always_comb begin
        timer_d = active ? timer_q + 1'b1 : 16'h0000;
        ptime_d = push_d ? timer_q : ptime_q;
    end

    // Timestamp follows the pending push one cycle behind, like the data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer_q <= '0;
            ptime_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tmem_q[i] <= '0;
        end else begin
            timer_q <= timer_d;
            ptime_q <= ptime_d;
            if (active && push_ok) tmem_q[wr_ptr_q[PTR_W-1:0]] <= ptime_q;
        end
    end

    assign evt_time = tmem_q[rd_ptr_q[PTR_W-1:0]];
`endif

endmodule

// File: tb/tb_analog_io_sampler.sv
// Self-checking bench for analog_io_sampler: directed steps plus random traffic vs a queue-based model.
module tb_analog_io_sampler;

    localparam int PADS       = 38;
    localparam int DEBOUNCE_W = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_MAX    = (1 << DEBOUNCE_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic                  active;
    logic [PADS-1:0]       io_in;
    logic [PADS-1:0]       io_mask;
    logic [DEBOUNCE_W-1:0] dbc;
    logic [PADS-1:0]       in_stable;
    logic                  evt_valid;
    logic                  evt_ready;
    logic [PADS-1:0]       evt_data;
    logic                  evt_overflow;
    logic                  clear_ovf;
`ifdef ANALOG_SAMPLER_TIMESTAMP_EN
    logic [15:0]           evt_time;
`endif

    int checks = 0;
    int errors = 0;

    analog_io_sampler #(
        .PADS(PADS), .DEBOUNCE_W(DEBOUNCE_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_ni      (rst_n),
        .active         (active),
        .io_in          (io_in),
        .io_mask        (io_mask),
        .debounce_cycles(dbc),
        .in_stable      (in_stable),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .evt_overflow   (evt_overflow),
        .clear_overflow (clear_ovf)
`ifdef ANALOG_SAMPLER_TIMESTAMP_EN
        ,
        .evt_time       (evt_time)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, advanced once per clock edge from the rules of operation.
    logic [PADS-1:0] m_s1, m_s2, m_cand, m_stable, m_pdata;
    int              m_cnt;
    bit              m_pend, m_ovf;
    logic [PADS-1:0] m_q[$];
    logic [15:0]     m_timer, m_ptime;
    logic [15:0]     m_tq[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cand = '0; m_stable = '0; m_pdata = '0;
        m_cnt = 0; m_pend = 0; m_ovf = 0; m_timer = '0; m_ptime = '0;
        m_q.delete(); m_tq.delete();
    endtask

    task automatic model_edge();
        logic [PADS-1:0] masked;
        bit pop, ovf_evt, npend;
        if (!rst_n) begin
            model_reset();
            return;
        end
        masked = m_s2 & io_mask;
        if (!active) begin
            m_cand = '0; m_cnt = 0; m_stable = '0; m_pend = 0; m_ovf = 0; m_timer = '0;
            m_q.delete(); m_tq.delete();
        end else begin
            pop = (m_q.size() != 0) && evt_ready;
            ovf_evt = 0;
            if (pop) begin
                void'(m_q.pop_front());
                void'(m_tq.pop_front());
            end
            if (m_pend) begin
                if (m_q.size() < FIFO_DEPTH) begin
                    m_q.push_back(m_pdata);
                    m_tq.push_back(m_ptime);
                end else ovf_evt = 1;
            end
            m_ovf = (m_ovf && !clear_ovf) || ovf_evt;
            npend = 0;
            if (masked != m_cand) begin
                m_cand = masked;
                m_cnt = 0;
            end else if (m_cand != m_stable) begin
                if (m_cnt == int'(dbc)) begin
                    m_stable = m_cand;
                    m_pdata = m_cand;
                    m_ptime = m_timer;
                    npend = 1;
                end else if (m_cnt < CNT_MAX) m_cnt++;
            end
            m_pend = npend;
            m_timer = m_timer + 16'd1;
        end
        m_s2 = m_s1;
        m_s1 = io_in;
    endtask

    task automatic chk(input string tag, input logic [PADS-1:0] obs, input logic [PADS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model, let the edge pass, compare the observable outputs.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_in_stable", in_stable, m_stable);
        chk1("model_evt_valid", evt_valid, m_q.size() != 0);
        chk1("model_overflow", evt_overflow, m_ovf);
        if (m_q.size() != 0) begin
            chk("model_evt_data", evt_data, m_q[0]);
`ifdef ANALOG_SAMPLER_TIMESTAMP_EN
            chk16("model_evt_time", evt_time, m_tq[0]);
`endif
        end
    endtask

    task automatic wait_pend(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (m_pend) found = 1;
        end
        chk1(tag, found, 1'b1);
    endtask

    initial begin
        logic [63:0] r64;
        rst_n = 1'b0; active = 1'b0; io_in = '0; io_mask = '0; dbc = '0;
        evt_ready = 1'b0; clear_ovf = 1'b0;
        model_reset();
        #1;
        repeat (3) step();
        chk("rst_in_stable", in_stable, '0);
        chk1("rst_evt_valid", evt_valid, 1'b0);
        chk("rst_evt_data", evt_data, '0);
        chk1("rst_overflow", evt_overflow, 1'b0);

        rst_n = 1'b1; active = 1'b1; io_mask = '1; dbc = '0;
        repeat (2) step();

        // First change with zero debounce: in_stable at k+3, evt_valid at k+4.
        io_in[0] = 1'b1;
        repeat (3) step();
        chk("t1_stable_k2", in_stable, '0);
        step();
        chk("t1_stable_k3", in_stable, PADS'(1));
        chk1("t1_valid_k3", evt_valid, 1'b0);
        step();
        chk1("t1_valid_k4", evt_valid, 1'b1);
        chk("t1_data_k4", evt_data, PADS'(1));
        evt_ready = 1'b1; step(); evt_ready = 1'b0;
        chk1("t1_drained", evt_valid, 1'b0);

        io_in[0] = 1'b0;
        repeat (6) step();
        evt_ready = 1'b1; step(); evt_ready = 1'b0;

        // Debounce of 5: a 4-cycle glitch is filtered, a long hold is accepted at k+8.
        dbc = 8'd5;
        io_in[3] = 1'b1;
        repeat (4) step();
        io_in[3] = 1'b0;
        repeat (12) step();
        chk("t2_glitch_stable", in_stable, '0);
        chk1("t2_glitch_valid", evt_valid, 1'b0);
        io_in[3] = 1'b1;
        repeat (8) step();
        chk("t2_stable_k7", in_stable, '0);
        step();
        chk("t2_stable_k8", in_stable, PADS'(8));
        step();
        chk1("t2_valid_k9", evt_valid, 1'b1);
        chk("t2_data_k9", evt_data, PADS'(8));
        evt_ready = 1'b1; step(); evt_ready = 1'b0;

        // Mask: only pad 1 is of interest.
        io_mask = PADS'(2); dbc = '0;
        evt_ready = 1'b1; repeat (8) step(); evt_ready = 1'b0;
        io_in[0] = 1'b1;
        repeat (8) step();
        chk1("t3_masked_valid", evt_valid, 1'b0);
        chk("t3_masked_stable", in_stable, '0);
        io_in[1] = 1'b1;
        repeat (6) step();
        chk1("t3_pad1_valid", evt_valid, 1'b1);
        chk("t3_pad1_data", evt_data, PADS'(2));

        // Overflow: five changes into a four-entry FIFO, drained in order.
        io_mask = '1; io_in = '0;
        evt_ready = 1'b1; repeat (8) step(); evt_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            io_in = PADS'(i);
            repeat (5) step();
        end
        repeat (3) step();
        chk1("t4_overflow", evt_overflow, 1'b1);
        chk1("t4_full_valid", evt_valid, 1'b1);
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_order", evt_data, PADS'(i));
            step();
        end
        evt_ready = 1'b0;
        chk1("t4_empty", evt_valid, 1'b0);

        // clear_overflow coinciding with a new overflowing push leaves the flag set.
        for (int i = 6; i <= 9; i++) begin
            io_in = PADS'(i);
            repeat (5) step();
        end
        io_in = PADS'(10);
        wait_pend("t4_pend_seen");
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk1("t4_clear_vs_ovf", evt_overflow, 1'b1);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk1("t4_clear", evt_overflow, 1'b0);

        // Full FIFO with a simultaneous pop accepts the push.
        io_in = PADS'(11);
        wait_pend("t5_pend_seen");
        evt_ready = 1'b1; step();
        chk1("t5_no_overflow", evt_overflow, 1'b0);
        chk("t5_head", evt_data, PADS'(7));
        repeat (6) step();
        evt_ready = 1'b0;
        chk1("t5_empty", evt_valid, 1'b0);

        // Dropping active discards queued events; re-activation re-debounces from 0.
        io_in = PADS'(12); repeat (5) step();
        io_in = PADS'(13); repeat (5) step();
        chk1("t6_queued", evt_valid, 1'b1);
        active = 1'b0; step();
        chk1("t6_idle_valid", evt_valid, 1'b0);
        chk("t6_idle_stable", in_stable, '0);
        chk1("t6_idle_ovf", evt_overflow, 1'b0);
        step();
        active = 1'b1;
        repeat (3) step();
        chk1("t6_react_valid", evt_valid, 1'b1);
        chk("t6_react_data", evt_data, PADS'(13));
`ifdef ANALOG_SAMPLER_TIMESTAMP_EN
        chk16("t6_react_time", evt_time, 16'd1);
`endif
        evt_ready = 1'b1; repeat (3) step(); evt_ready = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) begin
                r64 = {$urandom(), $urandom()};
                io_in = r64[PADS-1:0];
            end
            if ($urandom_range(49) == 0) begin
                r64 = {$urandom(), $urandom()} | {$urandom(), $urandom()};
                io_mask = r64[PADS-1:0];
            end
            if ($urandom_range(39) == 0) dbc = DEBOUNCE_W'($urandom_range(4));
            evt_ready = ($urandom_range(2) == 0);
            clear_ovf = ($urandom_range(29) == 0);
            active    = ($urandom_range(99) != 0);
            step();
        end
        active = 1'b1; clear_ovf = 1'b0; evt_ready = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
